// File: rtl/bus_cycle_sched.sv
// Bus-cycle sequencer: phase-counter strobes, CPU/debug RAM time-sharing and CPU halt.
// Define BUS_SCHED_TRACE_EN to add the cpu_sync/cpu_rdata inputs and the trace output.
module bus_cycle_sched #(
    parameter int PERIOD   = 16,
    parameter int VIA_DIV  = 4,
    parameter int SLOT     = 8,
    parameter int PHI2_LOW = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset,
    input  logic        halt,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [12:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata,
    input  logic [7:0]  ram_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        cpu_clken,
    output logic        cpu_clken1,
    output logic        via_clken,
`ifdef BUS_SCHED_TRACE_EN
    input  logic        cpu_sync,
    input  logic [7:0]  cpu_rdata,
    output logic [10:0] trace,
`endif
    output logic        phi2
);

    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] LAST     = PW'(PERIOD - 1);
    localparam logic [PW-1:0] SLOT_P   = PW'(SLOT);
    localparam logic [PW-1:0] PHI2_CLR = PW'(PHI2_LOW - 1);
    localparam logic [PW-1:0] VIA_MASK = PW'(VIA_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DONE,
        WAITLOW
    } dbg_state_t;

    dbg_state_t state, state_next;

    logic [PW-1:0] p;
    logic [PW-1:0] p_next;
    logic          halt_q;
    logic          dbg_issue;
    logic [7:0]    rdata_q;

    assign p_next = p + PW'(1);

    // Strobes are computed one phase early so they are plain flops that read 0 in reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            p          <= '0;
            halt_q     <= 1'b0;
            cpu_clken  <= 1'b0;
            cpu_clken1 <= 1'b0;
            via_clken  <= 1'b0;
            phi2       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            p          <= p_next;
            cpu_clken  <= (p == LAST) && !halt;
            cpu_clken1 <= (p == '0) && !halt_q;
            via_clken  <= (p_next & VIA_MASK) == '0;
            if (p == LAST) begin
                halt_q <= halt;
            end
            if ((p == LAST) && !halt) begin
                phi2 <= 1'b1;
            end else if (p == PHI2_CLR) begin
                phi2 <= 1'b0;
            end
            if (state == DONE) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dbg_issue  = 1'b0;
        dbg_ack    = 1'b0;
        dbg_rdata  = rdata_q;
        case (state)
            IDLE: begin
                if (dbg_req) state_next = PEND;
            end
            PEND: begin
                if (p == SLOT_P) begin
                    dbg_issue  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                dbg_ack    = 1'b1;
                dbg_rdata  = ram_rdata;
                state_next = WAITLOW;
            end
            WAITLOW: begin
                if (!dbg_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The CPU slot (phase 1) and the debug slot can never overlap since SLOT >= 3.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_clken1) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (dbg_issue) begin
            ram_en    = 1'b1;
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end
    end

`ifdef BUS_SCHED_TRACE_EN
    logic       trace_sync;
    logic       trace_rnw;
    logic [7:0] trace_data;

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            trace_sync <= 1'b0;
            trace_rnw  <= 1'b0;
            trace_data <= '0;
        end else if (cpu_clken) begin
            trace_sync <= cpu_sync;
            trace_rnw  <= !cpu_we;
            trace_data <= cpu_we ? cpu_wdata : cpu_rdata;
        end
    end

    assign trace = {phi2, trace_sync, trace_rnw, trace_data};
`endif

endmodule

// File: tb/tb_bus_cycle_sched.sv
// Scoreboard bench for bus_cycle_sched: phase-model strobe checks plus a debug-access queue.
module tb_bus_cycle_sched;

    localparam int PERIOD   = 16;
    localparam int SLOT     = 8;
    localparam int PHI2_LOW = 8;
    localparam int VIA_DIV  = 4;

    logic        cpu_clk   = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        halt      = 1'b0;
    logic [12:0] cpu_addr  = 13'h0AAA;
    logic        cpu_we    = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        dbg_req   = 1'b0;
    logic        dbg_we    = 1'b0;
    logic [12:0] dbg_addr  = '0;
    logic [7:0]  dbg_wdata = '0;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        ram_en;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        cpu_clken;
    logic        cpu_clken1;
    logic        via_clken;
    logic        phi2;

    bus_cycle_sched #(
        .PERIOD(PERIOD), .VIA_DIV(VIA_DIV), .SLOT(SLOT), .PHI2_LOW(PHI2_LOW)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .halt(halt),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .ram_rdata(ram_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_clken(cpu_clken), .cpu_clken1(cpu_clken1), .via_clken(via_clken),
        .phi2(phi2)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Write-first RAM with one-clock registered read data.
    logic [7:0] mem [0:8191];
    always @(posedge cpu_clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int ack_count = 0;

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference phase model built from the behavioural description.
    int   mp   = 0;
    logic mhq  = 1'b0;
    logic mrst = 1'b1;
    logic seen0 = 1'b0;
    always @(posedge cpu_clk) begin
        if (cpu_reset) begin
            mp <= 0; mhq <= 1'b0; mrst <= 1'b1; seen0 <= 1'b0;
        end else begin
            mp   <= (mp + 1) % PERIOD;
            mrst <= 1'b0;
            if (mp == PERIOD - 1) begin
                mhq   <= halt;
                seen0 <= 1'b1;
            end
        end
    end

    always @(negedge cpu_clk) begin
        logic exp_c1;
        exp_c1 = !mrst && (mp == 1) && !mhq;
        check_output("cpu_clken", cpu_clken, !mrst && (mp == 0) && !mhq);
        check_output("cpu_clken1", cpu_clken1, exp_c1);
        check_output("via_clken", via_clken, !mrst && (mp % VIA_DIV == 0));
        check_output("phi2", phi2, !mrst && seen0 && !mhq && (mp < PHI2_LOW));
        if (mp != SLOT) check_output("ram_en_cpu_slot", ram_en, exp_c1);
        if (exp_c1) begin
            check_output("ram_addr_cpu", ram_addr, cpu_addr);
            check_output("ram_we_cpu", ram_we, cpu_we);
        end
    end

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } txn_t;
    txn_t exp_q[$];

    // Monitor: checks debug RAM accesses and acks against the expected-transaction queue.
    always @(negedge cpu_clk) begin
        txn_t h;
        if (ram_en && mp == SLOT) begin
            check_output("dbg_access_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                check_output("dbg_ram_addr", ram_addr, h.addr);
                check_output("dbg_ram_we", ram_we, h.we);
                if (h.we) check_output("dbg_ram_wdata", ram_wdata, h.wdata);
            end
        end
        if (dbg_ack) begin
            ack_count++;
            check_output("ack_expected", exp_q.size() != 0, 1);
            check_output("ack_phase", mp, SLOT + 1);
            if (exp_q.size() != 0) begin
                h = exp_q.pop_front();
                if (!h.we) check_output("dbg_rdata", dbg_rdata, h.rdata);
            end
        end
    end

    task automatic wait_phase(int k);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge cpu_clk);
            if (mp == k) return;
        end
        check_output("wait_phase_timeout", 0, 1);
    endtask

    task automatic drive_at(int k);
        wait_phase(k);
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input logic [12:0] addr,
                                  input logic [7:0] wdata, input logic [7:0] exp_rdata);
        txn_t t;
        int   lat;
        logic got;
        t = '{we: we, addr: addr, wdata: wdata, rdata: exp_rdata};
        exp_q.push_back(t);
        @(posedge cpu_clk);
        #1;
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(posedge cpu_clk);
            lat++;
            @(negedge cpu_clk);
            if (dbg_ack) got = 1'b1;
        end
        check_output("ack_seen", got, 1);
        check_output("ack_latency_le_17", lat <= PERIOD + 1, 1);
        @(posedge cpu_clk);
        #1;
        dbg_req = 1'b0;
    endtask

    task automatic measure_clken(string name, int expected);
        int n = 0;
        logic got = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(posedge cpu_clk);
            n++;
            @(negedge cpu_clk);
            if (cpu_clken) got = 1'b1;
        end
        check_output(name, n, expected);
    endtask

    initial begin
        int a0;
        txn_t t;
        repeat (3) @(posedge cpu_clk);
        #1;
        cpu_reset = 1'b0;
        measure_clken("first_clken_clocks", 16);
        measure_clken("second_clken_clocks", 16);
        measure_clken("third_clken_clocks", 16);

        $display("[TB] debug write/read");
        apply_stimulus(1'b1, 13'h1234, 8'hA5, 8'h00);
        apply_stimulus(1'b0, 13'h1234, 8'h00, 8'hA5);
        apply_stimulus(1'b1, 13'h0000, 8'h5A, 8'h00);
        apply_stimulus(1'b1, 13'h1FFF, 8'hFF, 8'h00);
        apply_stimulus(1'b0, 13'h0000, 8'h00, 8'h5A);

        $display("[TB] CPU write then debug read in the same cycle");
        drive_at(2);
        cpu_addr = 13'h0100; cpu_wdata = 8'h77; cpu_we = 1'b1;
        wait_phase(2);
        apply_stimulus(1'b0, 13'h0100, 8'h00, 8'h77);
        drive_at(2);
        cpu_we = 1'b0; cpu_addr = 13'h0AAA;

        $display("[TB] halt mid-cycle with debug read");
        drive_at(4);
        halt = 1'b1;
        wait_phase(0);
        apply_stimulus(1'b0, 13'h1FFF, 8'h00, 8'hFF);
        drive_at(3);
        halt = 1'b0;
        repeat (2 * PERIOD) @(posedge cpu_clk);

        $display("[TB] held request");
        t = '{we: 1'b0, addr: 13'h1234, wdata: 8'h00, rdata: 8'hA5};
        exp_q.push_back(t);
        @(negedge cpu_clk);
        a0 = ack_count;
        @(posedge cpu_clk);
        #1;
        dbg_we = 1'b0; dbg_addr = 13'h1234; dbg_req = 1'b1;
        repeat (3 * PERIOD) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_output("held_req_one_ack", ack_count - a0, 1);
        #1;
        dbg_req = 1'b0;
        repeat (2) @(posedge cpu_clk);
        exp_q.push_back(t);
        #1;
        dbg_req = 1'b1;
        for (int i = 0; i < 2 * PERIOD && ack_count - a0 < 2; i++) @(negedge cpu_clk);
        check_output("reraise_second_ack", ack_count - a0, 2);
        @(posedge cpu_clk);
        #1;
        dbg_req = 1'b0;

        $display("[TB] reset while request pending");
        drive_at(10);
        dbg_we = 1'b0; dbg_addr = 13'h0000; dbg_req = 1'b1;
        @(posedge cpu_clk);
        #1;
        cpu_reset = 1'b1;
        dbg_req   = 1'b0;
        @(negedge cpu_clk);
        a0 = ack_count;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_reset = 1'b0;
        measure_clken("clken_after_reset_clocks", 16);
        repeat (2 * PERIOD) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_output("no_ack_after_reset", ack_count - a0, 0);
        apply_stimulus(1'b0, 13'h1234, 8'h00, 8'hA5);

        repeat (4) @(posedge cpu_clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bus_cycle_sched.md
Name: bus_cycle_sched

Overview:
- Central bus-cycle sequencer for the 16 MHz system. It derives all per-cycle strobes from one phase counter: CPU RDY/clock-enable, the delayed memory/peripheral strobe, the VIA enable and phi2.
- It time-shares the 8 KB RAM port between the 65C02 and a debug requester (UART monitor/loader) using a fixed mid-cycle slot.
- It can freeze the CPU without stopping the phase counter or debug accesses.

Parameters:
- PERIOD, 16: cpu_clk cycles per CPU bus cycle. Must be a power of two, at least 8.
- VIA_DIV, 4: via_clken divider. Power of two, divides PERIOD.
- SLOT, 8: phase at which the debug RAM access is issued. Legal range is 3..PERIOD-2.
- PHI2_LOW, 8: phase at which phi2 falls.

Ports:
- cpu_clk  in  1  system clock
- cpu_reset  in  1  synchronous, active-high reset
- halt  in  1  level; freezes CPU bus cycles while high
- cpu_addr  in  13  CPU RAM address (registered bus address)
- cpu_we  in  1  CPU write, already qualified with RAM select
- cpu_wdata  in  8  CPU write data
- dbg_req  in  1  debug request level, held until dbg_ack
- dbg_we  in  1  debug write
- dbg_addr  in  13  debug RAM address
- dbg_wdata  in  8  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  8  debug read data, valid while dbg_ack is high
- ram_rdata  in  8  RAM registered read data (one-clock latency)
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write
- ram_addr  out  13  RAM address
- ram_wdata  out  8  RAM write data
- cpu_clken  out  1  CPU RDY / bus-register load strobe
- cpu_clken1  out  1  memory/peripheral access strobe
- via_clken  out  1  VIA ENA_4 strobe
- phi2  out  1  phi2 level

Behaviour:
- Phase counter p:
  - Width is log2(PERIOD). It increments every clock and wraps PERIOD-1 to 0. It ignores halt.
  - Reset forces p=0.
  - On release p runs 1, 2, ...; the first cpu_clken occurs PERIOD clocks after the release edge.
- Reset values: all outputs 0, ram_addr/ram_wdata 0, pending and grant flags cleared.
- Strobes (one clock wide; all outputs are registered or decoded directly from registered state):
  - cpu_clken = (p==0) & ~halt_q
  - cpu_clken1 = (p==1) & ~halt_q
  - via_clken = (p mod VIA_DIV == 0), independent of halt
  - halt_q samples halt at p==PERIOD-1. Halt therefore takes or drops effect only on whole-cycle boundaries; a CPU cycle is never split.
- phi2: set at p==0 when not halted, cleared at p==PHI2_LOW. It stays low for the whole of a halted cycle.
- RAM port mux:
  - At p==1 with ~halt_q: ram_en=1, ram_we=cpu_we, address and data taken from the cpu_* inputs.
  - At p==SLOT with grant: ram_en=1, ram_we=dbg_we, address and data taken from the dbg_* inputs.
  - At all other times ram_en=0 and ram_we=0.
  - CPU and debug accesses can never coincide.
- Debug handshake state machine:
  - IDLE: go to PEND when dbg_req is high.
  - PEND: at p==SLOT issue the access and go to DONE. A request arriving at p==SLOT waits for the next cycle's slot.
  - DONE (always exactly one clock, at p==SLOT+1): dbg_ack=1 and dbg_rdata=ram_rdata (captured; holds until the next ack). Then go to WAITLOW.
  - WAITLOW: go to IDLE once dbg_req is low. No re-issue while dbg_req remains high.
  - Debug inputs must stay stable from request to ack.
- Throughput and latency: at most one debug access per PERIOD. Worst-case ack latency is PERIOD+1 clocks from request.
- Halt interaction: the debug slot is serviced while halted.
- Reset mid-operation: the state machine returns to IDLE, an in-flight ack is dropped, and the requester must re-assert.
- Writes are write-first from the RAM's view. A debug read of an address the CPU wrote in the same cycle returns the new data.

Optional Feature:
- Macro BUS_SCHED_TRACE_EN adds inputs cpu_sync (1), cpu_rdata (8) and outputs trace (11) = {phi2, sync, rnw, data}.
- Sync, rnw and data are captured at cpu_clken. On a write, data = cpu_wdata and rnw=0; otherwise data = cpu_rdata and rnw=1.
- The trace holds while halted.
- Without the macro these ports do not exist and no trace logic is built.

Test Plan:
- Reset release, defaults: cpu_clken pulses at clocks 16, 32, 48 after release. cpu_clken1 follows one clock later. via_clken every 4 clocks. phi2 high for phases 0..7.
- Debug write 0x1234 := 0xA5 then read: ram_en/ram_we asserted at p=8 with addr 0x1234. dbg_ack pulses at p=9. Readback returns dbg_rdata=0xA5.
- Halt asserted mid-cycle (p=5): current cycle completes. The next cycle has no cpu_clken, cpu_clken1 or phi2. via_clken continues. Deassert restores strobes from the following p=0.
- Debug read while halted: ack still arrives within 17 clocks. The CPU RAM port is never enabled.
- dbg_req held high for 3 cycles: exactly one ack. Drop and re-raise of dbg_req yields a second ack.
- cpu_reset asserted in PEND: no ack, state is IDLE and p=0 after release. With BUS_SCHED_TRACE_EN, a CPU write of 0x3C gives trace = {1,x,0,0x3C} after cpu_clken.
